// File: rtl/control_unit_pkg.sv
// Shared definitions for the control_unit sequencer: opcodes, FSM states and ALU selects.
// Also holds the helpers that map an opcode to its ALU operation and flag it as illegal.
package control_unit_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDR = 4'h1;
    localparam logic [3:0] OP_STR = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluPassB
    } alu_sel_e;

    function automatic alu_sel_e alu_sel_of(logic [3:0] op);
        case (op)
            OP_ADD:  return AluAdd;
            OP_SUB:  return AluSub;
            OP_AND:  return AluAnd;
            OP_OR:   return AluOr;
            default: return AluPassB;
        endcase
    endfunction

    function automatic logic op_is_illegal(logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/control_unit_alu8.sv
// alu8: combinational 8-bit ALU for the control_unit datapath (ADD/SUB/AND/OR/PASS-B).
// c is the carry for ADD and the borrow (a < b) for SUB; zero otherwise.
module alu8
    import control_unit_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  alu_sel_e   sel,
    output logic [7:0] y,
    output logic       c
);

    always_comb begin
        y = b;
        c = 1'b0;
        unique case (sel)
            AluAdd:  {c, y} = {1'b0, a} + {1'b0, b};
            AluSub: begin
                y = a - b;
                c = (a < b);
            end
            AluAnd:  y = a & b;
            AluOr:   y = a | b;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer with ACC and flags, driving regbank.
// Define CTRL_ILLEGAL_TRAP_EN to halt on opcodes A-E and expose the 'illegal' output.
module control_unit
    import control_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       rb_wr,
    output logic [1:0] rb_rs,
    output logic [7:0] rb_data,
    input  logic [7:0] rb_val,
    output logic [7:0] acc,
    output logic       flag_z,
    output logic       flag_c,
    output logic       halted
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic [3:0] op;
    logic [7:0] pc_inc;
    logic       trap;
    alu_sel_e   alu_sel;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       alu_c;
    logic       unused_ir_bits;

    assign op             = ir_q[7:4];
    assign pc_inc         = pc_q + 8'd1;
    assign unused_ir_bits = ^ir_q[3:2];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign trap    = op_is_illegal(op);
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_q == StExec && trap) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign trap = 1'b0;
`endif

    // LDI takes its operand straight off the ROM at pc; everything else uses the register read.
    assign alu_sel = alu_sel_of(op);
    assign alu_b   = (op == OP_LDI) ? imem_data : rb_val;

    alu8 u_alu (
        .a   (acc_q),
        .b   (alu_b),
        .sel (alu_sel),
        .y   (alu_y),
        .c   (alu_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            acc_q   <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = (op == OP_HLT || trap) ? StHalt : StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        z_d   = z_q;
        c_d   = c_q;
        if (state_q == StFetch) begin
            ir_d = imem_data;
            pc_d = pc_inc;
        end else if (state_q == StExec) begin
            case (op)
                OP_LDR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: begin
                    acc_d = alu_y;
                    z_d   = (alu_y == 8'h00);
                end
                default: ;
            endcase
            if (op == OP_ADD || op == OP_SUB) begin
                c_d = alu_c;
            end
            case (op)
                OP_LDI:  pc_d = pc_inc;
                OP_JMP:  pc_d = imem_data;
                OP_JZ:   pc_d = z_q ? imem_data : pc_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        rb_wr = (state_q == StExec) && (op == OP_STR);
        rb_rs = (state_q == StDecode || state_q == StExec) ? ir_q[1:0] : 2'b00;
    end

    assign imem_addr = pc_q;
    assign rb_data   = acc_q;
    assign acc       = acc_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit with a behavioural regbank and ROM; an instruction-level interpreter
// predicts architectural state after every instruction.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       rb_wr;
    logic [1:0] rb_rs;
    logic [7:0] rb_data;
    logic [7:0] rb_val;
    logic [7:0] acc;
    logic       flag_z;
    logic       flag_c;
    logic       halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    logic [7:0] rom [256];
    logic [7:0] rf [4];
    logic       rf_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pc, m_acc;
    logic       m_z, m_c, m_halt, m_ill;
    logic [7:0] m_regs [4];

    always #5 clk = ~clk;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .rb_wr     (rb_wr),
        .rb_rs     (rb_rs),
        .rb_data   (rb_data),
        .rb_val    (rb_val),
        .acc       (acc),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .halted    (halted)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    assign imem_data = rom[imem_addr];
    assign rb_val    = rf[rb_rs];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (rb_wr) begin
            rf[rb_rs] <= rb_data;
        end
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Instruction-set interpreter: one call retires one instruction.
    task automatic model_exec();
        logic [7:0] b, p1, opnd, rv;
        logic [8:0] sum;
        logic [1:0] r;
        if (m_halt) return;
        b    = rom[m_pc];
        r    = b[1:0];
        p1   = m_pc + 8'd1;
        opnd = rom[p1];
        rv   = m_regs[r];
        m_pc = p1;
        case (b[7:4])
            4'h1: begin m_acc = rv; m_z = (m_acc == 8'h00); end
            4'h2: m_regs[r] = m_acc;
            4'h3: begin
                sum   = {1'b0, m_acc} + {1'b0, rv};
                m_acc = sum[7:0];
                m_c   = sum[8];
                m_z   = (m_acc == 8'h00);
            end
            4'h4: begin
                m_c   = (m_acc < rv);
                m_acc = m_acc - rv;
                m_z   = (m_acc == 8'h00);
            end
            4'h5: begin m_acc = m_acc & rv; m_z = (m_acc == 8'h00); end
            4'h6: begin m_acc = m_acc | rv; m_z = (m_acc == 8'h00); end
            4'h7: begin m_acc = opnd; m_z = (m_acc == 8'h00); m_pc = p1 + 8'd1; end
            4'h8: m_pc = opnd;
            4'h9: m_pc = m_z ? opnd : p1 + 8'd1;
            4'hF: m_halt = 1'b1;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (b[7:4] >= 4'hA) begin
                    m_halt = 1'b1;
                    m_ill  = 1'b1;
                end
`endif
            end
        endcase
    endtask

    // Runs three clocks from just after a posedge, checking bus behaviour each cycle.
    task automatic run_instr(input string tag);
        logic [7:0] b;
        logic       exp_wr;
        logic [1:0] exp_rs;
        b = rom[m_pc];
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            exp_wr = !m_halt && cyc == 2 && b[7:4] == 4'h2;
            exp_rs = (!m_halt && cyc != 0) ? b[1:0] : 2'b00;
            chk1({tag, ".rb_wr"}, rb_wr, exp_wr);
            chk8({tag, ".rb_rs"}, {6'd0, rb_rs}, {6'd0, exp_rs});
            chk8({tag, ".rb_data"}, rb_data, m_acc);
            @(posedge clk);
        end
        model_exec();
        #1;
        chk8({tag, ".pc"}, imem_addr, m_pc);
        chk8({tag, ".acc"}, acc, m_acc);
        chk1({tag, ".z"}, flag_z, m_z);
        chk1({tag, ".c"}, flag_c, m_c);
        chk1({tag, ".halted"}, halted, m_halt);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk1({tag, ".illegal"}, illegal, m_ill);
`endif
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rf_clr = 1'b1;
        m_pc   = 8'h00;
        m_acc  = 8'h00;
        m_z    = 1'b0;
        m_c    = 1'b0;
        m_halt = 1'b0;
        m_ill  = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        rf_clr = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    initial begin
        logic [7:0] hold_pc, hold_acc;
        rst    = 1'b1;
        rf_clr = 1'b1;
        clear_rom();

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk8("rst.pc", imem_addr, 8'h00);
        chk8("rst.acc", acc, 8'h00);
        chk1("rst.z", flag_z, 1'b0);
        chk1("rst.c", flag_c, 1'b0);
        chk1("rst.halted", halted, 1'b0);
        chk1("rst.rb_wr", rb_wr, 1'b0);
        chk8("rst.rb_rs", {6'd0, rb_rs}, 8'h00);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk1("rst.illegal", illegal, 1'b0);
`endif

        // All-NOP ROM: pc advances one per instruction
        do_reset();
        for (int i = 0; i < 6; i++) run_instr("nop");
        chk8("nop.pc6", imem_addr, 8'h06);

        // Load/store, ADD/SUB with carry and borrow, JZ taken and not taken, HLT
        clear_rom();
        rom[8'h00] = 8'h70; rom[8'h01] = 8'h38;
        rom[8'h02] = 8'h20;
        rom[8'h03] = 8'h70; rom[8'h04] = 8'h2B;
        rom[8'h05] = 8'h2D;                     // STR r1 with ignored bits set
        rom[8'h06] = 8'h70; rom[8'h07] = 8'hF0;
        rom[8'h08] = 8'h22;
        rom[8'h09] = 8'h70; rom[8'h0A] = 8'h20;
        rom[8'h0B] = 8'h32;
        rom[8'h0C] = 8'h42;
        rom[8'h0D] = 8'h70; rom[8'h0E] = 8'h00;
        rom[8'h0F] = 8'h90; rom[8'h10] = 8'h40;
        rom[8'h40] = 8'h70; rom[8'h41] = 8'h01;
        rom[8'h42] = 8'h90; rom[8'h43] = 8'h40;
        rom[8'h44] = 8'hF0;
        do_reset();
        for (int i = 0; i < 4; i++) run_instr("ldst");
        chk8("ldst.r0", rf[0], 8'h38);
        chk8("ldst.r1", rf[1], 8'h2B);
        for (int i = 0; i < 4; i++) run_instr("add");
        chk8("add.acc", acc, 8'h10);
        chk1("add.c", flag_c, 1'b1);
        chk1("add.z", flag_z, 1'b0);
        run_instr("sub");
        chk8("sub.acc", acc, 8'h20);
        chk1("sub.c", flag_c, 1'b1);
        chk1("sub.z", flag_z, 1'b0);
        run_instr("jz");
        run_instr("jz");
        chk8("jz.taken.pc", imem_addr, 8'h40);
        run_instr("jz");
        run_instr("jz");
        chk8("jz.skip.pc", imem_addr, 8'h44);
        run_instr("hlt");
        chk1("hlt.halted", halted, 1'b1);
        hold_pc  = imem_addr;
        hold_acc = acc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("hold.rb_wr", rb_wr, 1'b0);
        end
        chk8("hold.pc", imem_addr, m_pc);
        chk8("hold.acc", acc, m_acc);
        chk8("hold.pc_stable", imem_addr, hold_pc);
        chk8("hold.acc_stable", acc, hold_acc);

        // JMP to FF, then LDI whose operand wraps to address 00
        clear_rom();
        rom[8'h00] = 8'h80; rom[8'h01] = 8'hFF;
        rom[8'hFF] = 8'h70;
        do_reset();
        run_instr("wrap");
        chk8("wrap.jmp.pc", imem_addr, 8'hFF);
        run_instr("wrap");
        chk8("wrap.ldi.acc", acc, 8'h80);
        chk8("wrap.ldi.pc", imem_addr, 8'h01);
        run_instr("wrap");
        chk1("wrap.halted", halted, 1'b1);

        // Reset asserted during the EXEC cycle of a STR
        clear_rom();
        rom[8'h00] = 8'h70; rom[8'h01] = 8'h55;
        rom[8'h02] = 8'h21;
        do_reset();
        run_instr("midrst");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk1("midrst.wr_before", rb_wr, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("midrst.rb_wr", rb_wr, 1'b0);
        chk8("midrst.pc", imem_addr, 8'h00);
        chk8("midrst.acc", acc, 8'h00);
        chk8("midrst.rb_rs", {6'd0, rb_rs}, 8'h00);
        chk1("midrst.halted", halted, 1'b0);
        chk1("midrst.z", flag_z, 1'b0);
        do_reset();
        chk8("midrst.r1", rf[1], 8'h00);

        // Opcode A: trap or NOP depending on build
        clear_rom();
        rom[8'h00] = 8'hA0;
        rom[8'h01] = 8'h70; rom[8'h02] = 8'h11;
        rom[8'h03] = 8'hF0;
        do_reset();
        run_instr("illeg");
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk1("illeg.halted", halted, 1'b1);
        chk1("illeg.flag", illegal, 1'b1);
        chk8("illeg.pc", imem_addr, 8'h01);
`else
        chk1("illeg.halted", halted, 1'b0);
        chk8("illeg.pc", imem_addr, 8'h01);
`endif
        run_instr("illeg");
        run_instr("illeg");

        // Random programs against the interpreter
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
            rom[8'h00] = 8'h70;
            do_reset();
            for (int i = 0; i < 30; i++) run_instr("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
